fetch_unit: RTL

// - Instruction-fetch stage of the pipelined RISC-V core. It sits between the PC, the instruction memory and decode.
// - Holds the fetch PC and issues word reads to a synchronous-read imem (1-cycle read latency).
// - Buffers the returned instructions in a small queue and presents them to decode with a valid/ready handshake.
// - Accepts branch/jump redirects from EX, which flush all younger fetches.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 110 +++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: imem read port, EX redirect input and the decode handshake.
// The master modport is the fetch unit's view; the slave modport is its environment.
interface fetch_unit_if #(
    parameter int XLEN    = 32,
    parameter int IMEM_AW = 10
);
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               if_valid;
    logic               if_ready;
    logic [XLEN-1:0]    if_pc;
    logic [31:0]        if_inst;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_inst,
        input  imem_rdata, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_inst,
        output imem_rdata, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited word reads from a 1-cycle imem into a small
// queue presented to decode, with EX redirects flushing every younger fetch.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2,
    parameter int              IMEM_AW  = 10
) (
    input  logic           clk,
    input  logic           rst,
    fetch_unit_if.master   bus
);
    localparam int              PW         = $clog2(QDEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [CW:0]     CREDITS    = (CW+1)'(QDEPTH);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(QDEPTH);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [31:0]     NOP        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    entry_t          queue [QDEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic            inflight;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;

    logic            head_valid;
    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     occupancy;

    // Occupancy counts queued entries plus the response still on its way, minus the
    // slot freed this cycle, so an issued read always has a slot when it returns.
    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        head_valid = 1'b0;
        pop        = 1'b0;
        push       = 1'b0;
        issue      = 1'b0;
        occupancy  = '0;

        head_valid = (count != '0);
        pop        = head_valid && bus.if_ready;
        push       = inflight && !bus.redirect_valid;
        occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
        issue      = !rst && !bus.redirect_valid && (occupancy < CREDITS);
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc[IMEM_AW+1:2];
    assign bus.if_valid  = head_valid;
    assign bus.if_pc     = head_valid ? queue[head].pc   : '0;
    assign bus.if_inst   = head_valid ? queue[head].inst : NOP;

    // A redirect discards the queue and the response arriving this cycle; since no read
    // is issued in a redirect cycle, nothing stale can arrive on the following one.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc & ALIGN_MASK;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + PC_STEP;
                req_pc   <= fetch_pc;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: queue storage has no reset; entries are only observed through head_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            queue[tail] <= '{pc: req_pc, inst: bus.imem_rdata};
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == FULL_COUNT)));

endmodule
